// File: rtl/fsm_success_tracker.sv
// Success-event tracker: one FIFO entry per rising edge of count==2'b11, 1-cycle push-to-rd_valid latency.
// Backpressure: rd_ready stalls the FWFT head; a push into a full FIFO without a same-cycle pop is dropped and sets overflow.
// Macro FSM_SUCCESS_TRACKER_STAMP_EN: entries hold the cycle stamp; otherwise they hold a wrapping sequence number.
module fsm_success_tracker #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               count,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [7:0]               success_total,
    output logic                     overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic {ARMED = 1'b0, HELD = 1'b1} state_t;

    state_t              state_q;
    logic                success_evt;
    logic                full;
    logic                push;
    logic                pop;
    logic [DATA_W-1:0]   entry;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [LVL_W-1:0]    level_q;
    logic [7:0]          total_q;
    logic                overflow_q;

    assign success_evt = (state_q == ARMED) && (count == 2'b11);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ARMED;
        end else begin
            case (state_q)
                ARMED:   state_q <= (count == 2'b11) ? HELD : ARMED;
                HELD:    state_q <= (count == 2'b11) ? HELD : ARMED;
                default: state_q <= ARMED;
            endcase
        end
    end

`ifdef FSM_SUCCESS_TRACKER_STAMP_EN
    logic [DATA_W-1:0] stamp_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stamp_q <= '0;
        end else begin
            stamp_q <= stamp_q + DATA_W'(1);
        end
    end

    assign entry = stamp_q;
`else
    // Advances on dropped events too, so a gap in the numbers read out marks a loss.
    logic [DATA_W-1:0] seq_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            seq_q <= '0;
        end else if (success_evt) begin
            seq_q <= seq_q + DATA_W'(1);
        end
    end

    assign entry = seq_q;
`endif

    assign full = (level_q == LVL_W'(DEPTH));
    assign pop  = rd_valid && rd_ready;
    assign push = success_evt && (!full || pop);

    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem_q[wr_ptr_q] <= entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            total_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
            if (success_evt && full && !pop) begin
                overflow_q <= 1'b1;
            end
            if (success_evt && (total_q != 8'hFF)) begin
                total_q <= total_q + 8'd1;
            end
        end
    end

    assign rd_valid      = (level_q != '0);
    assign rd_data       = mem_q[rd_ptr_q];
    assign fifo_level    = level_q;
    assign success_total = total_q;
    assign overflow      = overflow_q;
endmodule

// File: tb/tb_fsm_success_tracker.sv
// Directed bench for fsm_success_tracker (DEPTH=4, DATA_W=8); table of per-cycle vectors plus hand-written sequences.
module tb_fsm_success_tracker;
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] count;
    logic       rd_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic [2:0] fifo_level;
    logic [7:0] success_total;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       r;
        logic [1:0] c;
        logic       rdy;
        logic       v;
        logic [7:0] d;
        int         l;
        int         t;
        logic       o;
    } vec_t;

    vec_t tbl[$];

    fsm_success_tracker #(.DEPTH(4), .DATA_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .count         (count),
        .rd_ready      (rd_ready),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .fifo_level    (fifo_level),
        .success_total (success_total),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    // Expected entry content: sequence number by default, cycle stamp when the stamp build is selected.
    function automatic logic [7:0] exp_entry(input int seq, input int stamp);
`ifdef FSM_SUCCESS_TRACKER_STAMP_EN
        return 8'(stamp);
`else
        return 8'(seq);
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [1:0] c, input logic rdy);
        reset    = r;
        count    = c;
        rd_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic row(input logic r, input logic [1:0] c, input logic rdy, input logic v,
                       input logic [7:0] d, input int l, input int t, input logic o);
        vec_t x;
        x.r = r; x.c = c; x.rdy = rdy; x.v = v; x.d = d; x.l = l; x.t = t; x.o = o;
        tbl.push_back(x);
    endtask

    initial begin
        reset    = 1'b0;
        count    = 2'b00;
        rd_ready = 1'b0;

        // Rows 0-1 in reset (count=11 must not create events); then event edges at stamps 0,3,5,8,10,12.
        row(0, 2'b11, 0, 0, 8'd0,            0, 0, 0);
        row(0, 2'b11, 1, 0, 8'd0,            0, 0, 0);
        row(1, 2'b11, 0, 1, exp_entry(0, 0), 1, 1, 0);
        row(1, 2'b11, 0, 1, exp_entry(0, 0), 1, 1, 0);
        row(1, 2'b00, 0, 1, exp_entry(0, 0), 1, 1, 0);
        row(1, 2'b11, 0, 1, exp_entry(0, 0), 2, 2, 0);
        row(1, 2'b10, 0, 1, exp_entry(0, 0), 2, 2, 0);
        row(1, 2'b11, 0, 1, exp_entry(0, 0), 3, 3, 0);
        row(1, 2'b00, 1, 1, exp_entry(1, 3), 2, 3, 0);
        row(1, 2'b00, 0, 1, exp_entry(1, 3), 2, 3, 0);
        row(1, 2'b11, 0, 1, exp_entry(1, 3), 3, 4, 0);
        row(1, 2'b00, 0, 1, exp_entry(1, 3), 3, 4, 0);
        row(1, 2'b11, 0, 1, exp_entry(1, 3), 4, 5, 0);
        row(1, 2'b00, 0, 1, exp_entry(1, 3), 4, 5, 0);
        row(1, 2'b11, 0, 1, exp_entry(1, 3), 4, 6, 1);
        row(1, 2'b00, 1, 1, exp_entry(2, 5), 3, 6, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].c, tbl[i].rdy);
            chk($sformatf("vec%0d_valid", i), int'(rd_valid), int'(tbl[i].v));
            if (tbl[i].v) begin
                chk($sformatf("vec%0d_data", i), int'(rd_data), int'(tbl[i].d));
            end
            chk($sformatf("vec%0d_level", i), int'(fifo_level), tbl[i].l);
            chk($sformatf("vec%0d_total", i), int'(success_total), tbl[i].t);
            chk($sformatf("vec%0d_ovf", i), int'(overflow), int'(tbl[i].o));
        end

        // Full FIFO: event coinciding with a pop keeps level at 4 and does not overflow.
        step(0, 2'b00, 0);
        chk("fp_reset_valid", int'(rd_valid), 0);
        chk("fp_reset_ovf", int'(overflow), 0);
        for (int k = 0; k < 4; k++) begin
            step(1, 2'b11, 0);
            step(1, 2'b00, 0);
        end
        chk("fp_full_level", int'(fifo_level), 4);
        step(1, 2'b11, 1);
        chk("fp_pp_level", int'(fifo_level), 4);
        chk("fp_pp_ovf", int'(overflow), 0);
        chk("fp_pp_total", int'(success_total), 5);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("fp_drain%0d_valid", k), int'(rd_valid), 1);
            chk($sformatf("fp_drain%0d_data", k), int'(rd_data), int'(exp_entry(k, 2 * k)));
            step(1, 2'b00, 1);
        end
        chk("fp_empty_level", int'(fifo_level), 0);
        chk("fp_empty_valid", int'(rd_valid), 0);

        // Reset mid-run with count held at 11, then release.
        step(0, 2'b00, 0);
        for (int k = 0; k < 3; k++) begin
            step(1, 2'b11, 0);
            step(1, 2'b00, 0);
        end
        chk("rst_pre_level", int'(fifo_level), 3);
        step(0, 2'b11, 1);
        chk("rst_valid", int'(rd_valid), 0);
        chk("rst_total", int'(success_total), 0);
        chk("rst_level", int'(fifo_level), 0);
        step(1, 2'b11, 0);
        chk("rst_rel_valid", int'(rd_valid), 1);
        chk("rst_rel_data", int'(rd_data), int'(exp_entry(0, 0)));
        chk("rst_rel_total", int'(success_total), 1);
        step(1, 2'b11, 0);
        step(1, 2'b11, 0);
        chk("rst_hold_total", int'(success_total), 1);
        chk("rst_hold_level", int'(fifo_level), 1);

        // 300 events with the consumer always ready: counter saturates, entry numbering wraps.
        step(0, 2'b00, 0);
        for (int k = 0; k < 300; k++) begin
            step(1, 2'b11, 1);
            chk($sformatf("sat_ev%0d_data", k), int'(rd_data), int'(exp_entry(k % 256, (2 * k) % 256)));
            chk($sformatf("sat_ev%0d_level", k), int'(fifo_level), 1);
            step(1, 2'b00, 1);
        end
        chk("sat_total", int'(success_total), 255);
        chk("sat_level", int'(fifo_level), 0);
        chk("sat_ovf", int'(overflow), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fsm_success_tracker.md
FSM_SUCCESS_TRACKER -- requirements
Module: fsm_success_tracker

Interface
REQ-001 Parameter DEPTH, default 4: event FIFO depth in entries; power of two, 2..16.
REQ-002 Parameter DATA_W, default 8: width of rd_data, cycle stamp and sequence counters.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 Port count, input, 2: state output of the upstream fsm; 2'b11 marks a completed sequence.
REQ-006 Port rd_ready, input, 1: consumer accepts the head entry this cycle.
REQ-007 Port rd_valid, output, 1: FIFO non-empty; rd_data holds a valid entry.
REQ-008 Port rd_data, output, DATA_W: head FIFO entry, first-word fall-through.
REQ-009 Port fifo_level, output, $clog2(DEPTH)+1: current number of stored entries.
REQ-010 Port success_total, output, 8: number of detected successes, saturating.
REQ-011 Port overflow, output, 1: sticky flag; an event was dropped because the FIFO was full.

Function
REQ-012 Tracker FSM SHALL have two states: ARMED and HELD.
REQ-013 In ARMED, with count==2'b11 sampled, the FSM SHALL go to HELD and raise a one-cycle internal event; otherwise it SHALL stay in ARMED.
REQ-014 In HELD, with count!=2'b11 sampled, the FSM SHALL go to ARMED; count held at 2'b11 for N cycles SHALL produce exactly one event.
REQ-015 The free-running stamp counter SHALL increment by 1 every cycle, DATA_W bits wide, and wrap from all-ones to 0.
REQ-016 On an event, the entry SHALL be pushed at the same rising edge that samples count==2'b11; rd_valid SHALL be high in the following cycle (1-cycle latency).
REQ-017 Pop SHALL occur when rd_valid && rd_ready; with rd_valid low, rd_ready SHALL be ignored.
REQ-018 Order SHALL be strict FIFO; rd_data SHALL stay stable while rd_valid is high and rd_ready is low.
REQ-019 Push and pop in the same cycle SHALL both occur, including when the FIFO is full; fifo_level SHALL be unchanged.
REQ-020 Push while full without a same-cycle pop SHALL drop the new entry and set overflow; stored entries SHALL be unaffected.
REQ-021 Overflow SHALL remain set until reset.
REQ-022 success_total SHALL increment on every event, whether pushed or dropped, and saturate at 8'hFF.
REQ-023 FIFO read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-024 With reset==0 at a rising edge, the block SHALL enter ARMED and clear the FIFO (rd_valid=0, fifo_level=0), success_total=0, overflow=0, stamp counter=0 and sequence counter=0.
REQ-025 Reset SHALL take priority over push and pop in the same cycle; count==2'b11 sampled during reset SHALL NOT produce an event.
REQ-026 After reset is released, count still at 2'b11 SHALL produce one event on the first sampled edge (state is ARMED).
REQ-027 rd_data SHALL be don't-care while rd_valid==0.

Configuration
REQ-028 Macro FSM_SUCCESS_TRACKER_STAMP_EN SHALL select the FIFO entry content.
REQ-029 Defined: each entry SHALL be the stamp counter value sampled at the event edge.
REQ-030 Undefined: each entry SHALL be a DATA_W-bit wrapping sequence number (first event after reset = 0, then 1, 2, ...), and the stamp counter SHALL be omitted.

Verification
REQ-031 Stamp: macro on, reset released at stamp 0; count=2'b11 sampled at stamp 5 -> next cycle rd_valid=1, rd_data=5, success_total=1, fifo_level=1.
REQ-032 Hold: count=2'b11 held 10 cycles, then 2'b00, then 2'b11 again -> exactly 2 entries, success_total=2.
REQ-033 Overflow: DEPTH=4, rd_ready=0, 5 separate events -> fifo_level=4, overflow=1, success_total=5, and the 4 oldest entries are read out in order.
REQ-034 Full push/pop: FIFO full, event coincides with rd_ready=1 -> head popped, new entry stored, fifo_level stays 4, overflow stays 0.
REQ-035 Reset mid-run: 3 entries queued, reset=0 for one edge with count=2'b11 -> rd_valid=0, success_total=0; after release with count still 2'b11 -> one event (sequence number 0 when macro off).
REQ-036 Saturation/wrap: 300 events with rd_ready=1 -> success_total=8'hFF; with macro off, the sequence number wraps 255->0.
